ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Round-robin arbiter and sequencer sharing one single_ram between NUM_PORTS
// requesters. Each requester issues single-word reads or writes over a
// level req / one-cycle ack handshake. One transaction takes three cycles:
// IDLE (arbitrate) -> ACCESS (RAM pins active) -> RESP (ack pulse).
//
// Ports
//   clk        : single clock, shared with the RAM
//   rst_n      : asynchronous active-low reset
//   req        : per-port request level
//   req_we     : per-port direction, 1 = write, 0 = read
//   req_addr   : flattened addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  : flattened write data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        : one-hot completion pulse, one cycle long
//   rdata      : read data, valid while the matching ack bit is high
//   busy       : high in ACCESS and RESP
//   ram_addr   : RAM address
//   ram_data   : bidirectional RAM data bus
//   ram_cs/we/oe : RAM chip select, write enable, output enable
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    inout  wire  [DATA_WIDTH-1:0]           ram_data,
    output logic                            ram_cs,
    output logic                            ram_we,
    output logic                            ram_oe
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // One extra bit so ptr + offset can exceed NUM_PORTS before wrapping.
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] port_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } port_req_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                    state;
    port_t                     ptr;
    port_t                     win;
    logic                      drv_en;
    logic [DATA_WIDTH-1:0]     drv_data;

    port_req_t [NUM_PORTS-1:0] port_req;
    logic                      grant_vld;
    port_t                     grant_idx;
    logic [CW-1:0]             cand;
    logic [NUM_PORTS-1:0]      ack_win;
    port_t                     ptr_next;

    // Unpack the flattened request buses into one record per port.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign port_req[i].we    = req_we[i];
        assign port_req[i].addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_req[i].wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting at ptr. The loop runs from the farthest
    // offset down to offset 0 so the requester nearest to ptr is the last
    // to assign and therefore wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(NUM_PORTS)) begin
                cand = cand - CW'(NUM_PORTS);
            end
            if (req[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        ack_win      = '0;
        ack_win[win] = 1'b1;
    end

    assign ptr_next = (win == port_t'(NUM_PORTS - 1)) ? '0 : win + port_t'(1);

    // Sequencer. Every output is a flop so the RAM pins and the bus drive
    // enable change only on clock edges and clear together on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            win      <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            ram_addr <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            drv_en   <= 1'b0;
            drv_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        state    <= S_ACCESS;
                        win      <= grant_idx;
                        busy     <= 1'b1;
                        ram_cs   <= 1'b1;
                        ram_addr <= port_req[grant_idx].addr;
                        ram_we   <= port_req[grant_idx].we;
                        ram_oe   <= ~port_req[grant_idx].we;
                        drv_en   <= port_req[grant_idx].we;
                        drv_data <= port_req[grant_idx].wdata;
                    end
                end

                S_ACCESS: begin
                    // The RAM loaded its output register on the falling
                    // edge mid-cycle, so the bus is settled here.
                    if (ram_oe) begin
                        rdata <= ram_data;
                    end
                    state    <= S_RESP;
                    ack      <= ack_win;
                    ram_cs   <= 1'b0;
                    ram_we   <= 1'b0;
                    ram_oe   <= 1'b0;
                    ram_addr <= '0;
                    drv_en   <= 1'b0;
                end

                S_RESP: begin
                    state <= S_IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                    ptr   <= ptr_next;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Driven only while a write is in ACCESS; the RAM drives only when
    // cs & oe & ~we, which can never coincide with a write cycle.
    assign ram_data = drv_en ? drv_data : {DATA_WIDTH{1'bz}};

endmodule
